// File: rtl/rate_divider_counter_if.sv
// Control/status bundle between the rate mux side and the rate divider counter.
interface rate_divider_counter_if #(
  parameter int unsigned RATE_W  = 20,
  parameter int unsigned COUNT_W = 4
);

  logic               enable;
  logic [RATE_W-1:0]  rate_load;
  logic               par_load;
  logic [COUNT_W-1:0] load_value;
  logic               tick;
  logic [COUNT_W-1:0] count;
  logic [RATE_W-1:0]  rate_count;

  modport master (
    output enable,
    output rate_load,
    output par_load,
    output load_value,
    input  tick,
    input  count,
    input  rate_count
  );

  modport slave (
    input  enable,
    input  rate_load,
    input  par_load,
    input  load_value,
    output tick,
    output count,
    output rate_count
  );

endinterface

// File: rtl/rate_divider_counter.sv
// Rate divider: reloadable down-counter that divides the clock by (rate_load+1),
// emitting a one-cycle tick that advances a wrapping display counter.
module rate_divider_counter #(
  parameter int unsigned RATE_W  = 20,
  parameter int unsigned COUNT_W = 4
) (
  input logic                  clock,
  input logic                  reset,
  rate_divider_counter_if.slave bus
);

  logic [RATE_W-1:0]  rateCountReg;
  logic [RATE_W-1:0]  rateCountNext;
  logic [COUNT_W-1:0] countReg;
  logic [COUNT_W-1:0] countNext;
  logic               tickReg;
  logic               tickNext;
  logic [RATE_W-1:0]  lastRate;
  logic               rateChange;

  // A new mux selection restarts the period at once instead of waiting out the old one.
  assign rateChange = (bus.rate_load != lastRate);

  // Track the rate input every edge, independent of enable, to detect changes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lastRate <= '0;
    end else begin
      lastRate <= bus.rate_load;
    end
  end

  // Next-state selection in priority order: load, pause, rate change, terminal, count down.
  always_comb begin
    rateCountNext = rateCountReg;
    countNext     = countReg;
    tickNext      = 1'b0;
    if (bus.par_load) begin
      countNext     = bus.load_value;
      rateCountNext = bus.rate_load;
    end else if (!bus.enable) begin
      rateCountNext = rateCountReg;
    end else if (rateChange) begin
      rateCountNext = bus.rate_load;
    end else if (rateCountReg == '0) begin
      rateCountNext = bus.rate_load;
      countNext     = countReg + COUNT_W'(1);
      tickNext      = 1'b1;
    end else begin
      rateCountNext = rateCountReg - RATE_W'(1);
    end
  end

  // Divider and display state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rateCountReg <= '0;
      countReg     <= '0;
      tickReg      <= 1'b0;
    end else begin
      rateCountReg <= rateCountNext;
      countReg     <= countNext;
      tickReg      <= tickNext;
    end
  end

  assign bus.tick       = tickReg;
  assign bus.count      = countReg;
  assign bus.rate_count = rateCountReg;

endmodule

// File: tb/tb_rate_divider_counter.sv
// Self-checking bench for rate_divider_counter: directed scenarios plus random traffic,
// compared every cycle against a period/elapsed-time model of the divider.
module tb_rate_divider_counter;

  localparam int unsigned RW = 20;
  localparam int unsigned CW = 4;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  rate_divider_counter_if #(.RATE_W(RW), .COUNT_W(CW)) bus ();

  rate_divider_counter #(.RATE_W(RW), .COUNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit chkEn    = 1'b0;

  // Model: a period that started with length base, elapsed cycles into it, display value.
  typedef struct packed {
    logic [31:0] base;
    logic [31:0] elapsed;
    logic [31:0] cnt;
    logic        tk;
  } mstate_t;

  mstate_t     mS;
  logic [31:0] mLast;

  function automatic mstate_t applyEdge(mstate_t s, logic [31:0] last, logic en, logic par,
                                        logic [31:0] rl, logic [31:0] lv);
    mstate_t n;
    n    = s;
    n.tk = 1'b0;
    if (par) begin
      n.base    = rl;
      n.elapsed = 0;
      n.cnt     = lv;
    end else if (!en) begin
      n.tk = 1'b0;
    end else if (rl != last) begin
      n.base    = rl;
      n.elapsed = 0;
    end else if (s.elapsed == s.base) begin
      n.cnt     = (s.cnt + 1) % (32'd1 << CW);
      n.base    = rl;
      n.elapsed = 0;
      n.tk      = 1'b1;
    end else begin
      n.elapsed = s.elapsed + 1;
    end
    return n;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mS    <= '0;
      mLast <= '0;
    end else begin
      mS    <= applyEdge(mS, mLast, bus.enable, bus.par_load, 32'(bus.rate_load),
                         32'(bus.load_value));
      mLast <= 32'(bus.rate_load);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chkEn) begin
      check("model_rate_count", 32'(bus.rate_count), mS.base - mS.elapsed);
      check("model_count", 32'(bus.count), mS.cnt);
      check("model_tick", 32'(bus.tick), 32'(mS.tk));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic waitRate(input logic [RW-1:0] val, input int budget, input string name);
    bit found;
    found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (bus.rate_count == val) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check(name, 32'(found), 32'd1);
  endtask

  task automatic checkZeros(input string tag);
    check({tag, "_count"}, 32'(bus.count), 0);
    check({tag, "_rate_count"}, 32'(bus.rate_count), 0);
    check({tag, "_tick"}, 32'(bus.tick), 0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.enable     = 1'b0;
    bus.rate_load  = '0;
    bus.par_load   = 1'b0;
    bus.load_value = '0;
    cyc(3);
    chkEn = 1'b1;
    checkZeros("reset");

    // Steady rate 3: one reload edge, then advance every 4 cycles.
    reset         = 1'b0;
    bus.rate_load = RW'(3);
    bus.enable    = 1'b1;
    cyc(1);
    check("steady_reload_rc", 32'(bus.rate_count), 3);
    check("steady_reload_tick", 32'(bus.tick), 0);
    cyc(3);
    check("steady_rc0", 32'(bus.rate_count), 0);
    cyc(1);
    check("steady_first_count", 32'(bus.count), 1);
    check("steady_first_tick", 32'(bus.tick), 1);
    check("steady_first_rc", 32'(bus.rate_count), 3);
    cyc(1);
    check("steady_tick_drop", 32'(bus.tick), 0);
    cyc(3);
    check("steady_second_count", 32'(bus.count), 2);

    // Full speed with wrap.
    bus.rate_load  = '0;
    bus.par_load   = 1'b1;
    bus.load_value = CW'(4'hE);
    cyc(1);
    bus.par_load = 1'b0;
    check("wrap_load_count", 32'(bus.count), 32'hE);
    check("wrap_load_tick", 32'(bus.tick), 0);
    cyc(1);
    check("wrap_F", 32'(bus.count), 32'hF);
    check("wrap_F_tick", 32'(bus.tick), 1);
    cyc(1);
    check("wrap_0", 32'(bus.count), 0);
    check("wrap_0_tick", 32'(bus.tick), 1);
    cyc(1);
    check("wrap_1", 32'(bus.count), 1);

    // Parallel load mid-period.
    bus.rate_load = RW'(10);
    waitRate(RW'(6), 30, "pload_wait");
    bus.par_load   = 1'b1;
    bus.load_value = CW'(4'hA);
    cyc(1);
    bus.par_load = 1'b0;
    check("pload_count", 32'(bus.count), 32'hA);
    check("pload_rc", 32'(bus.rate_count), 10);
    check("pload_tick", 32'(bus.tick), 0);
    cyc(10);
    check("pload_hold", 32'(bus.count), 32'hA);
    cyc(1);
    check("pload_adv", 32'(bus.count), 32'hB);
    check("pload_adv_tick", 32'(bus.tick), 1);

    // Pause for 20 cycles at rate_count 2.
    bus.rate_load = RW'(5);
    waitRate(RW'(2), 30, "pause_wait");
    bus.enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      check("pause_rc", 32'(bus.rate_count), 2);
      check("pause_tick", 32'(bus.tick), 0);
    end
    bus.enable = 1'b1;
    cyc(2);
    check("resume_rc0", 32'(bus.rate_count), 0);
    cyc(1);
    check("resume_tick", 32'(bus.tick), 1);

    // Rate change mid-period.
    bus.rate_load = RW'(1000);
    waitRate(RW'(500), 1100, "rchg_wait");
    bus.rate_load = RW'(2);
    cyc(1);
    check("rchg_rc", 32'(bus.rate_count), 2);
    check("rchg_tick", 32'(bus.tick), 0);
    cyc(3);
    check("rchg_adv1", 32'(bus.tick), 1);
    cyc(3);
    check("rchg_adv2", 32'(bus.tick), 1);

    // Widest reload value.
    bus.rate_load = RW'(20'hFFFFF);
    bus.par_load  = 1'b1;
    cyc(1);
    bus.par_load = 1'b0;
    check("max_rc", 32'(bus.rate_count), 32'hFFFFF);
    cyc(1);
    check("max_rc_dec", 32'(bus.rate_count), 32'hFFFFE);

    // Async reset mid-operation.
    bus.rate_load  = RW'(600);
    bus.par_load   = 1'b1;
    bus.load_value = CW'(7);
    cyc(1);
    bus.par_load = 1'b0;
    waitRate(RW'(300), 400, "areset_wait");
    check("areset_pre_count", 32'(bus.count), 7);
    #2 reset = 1'b1;
    #1 checkZeros("areset");
    cyc(2);
    reset = 1'b0;
    cyc(4);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      bus.enable     = ($urandom_range(0, 9) != 0);
      bus.par_load   = ($urandom_range(0, 29) == 0);
      bus.load_value = CW'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 9) == 0) bus.rate_load = RW'($urandom_range(0, 300));
        else bus.rate_load = RW'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b1;
        #1 checkZeros("rand_reset");
        @(negedge clock);
        reset = 1'b0;
      end
    end

    cyc(2);
    chkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
